// File: rtl/spi_pkg.sv
// Shared parameters, FSM state encoding and select-validity helper for the
// single-master, four-slave SPI exchange model.
package spi_pkg;

    localparam int DATA_W   = 8;
    localparam int N_SLAVES = 4;
    localparam int CNT_W    = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_e;

    // A select is usable only when exactly one slave is addressed.
    function automatic logic is_onehot(input logic [N_SLAVES-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/spi_slave.sv
// One slave shift register: parallel load, MSB-first shift from mosi, and a
// gated serial output so only the addressed slave drives the return line.
module spi_slave
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic              sel_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              mosi_i,
    output logic [DATA_W-1:0] q_o,
    output logic              miso_o
);

    logic [DATA_W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (load_i)
            q_d = data_i;
        else if (shift_i)
            q_d = {q_q[DATA_W-2:0], mosi_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q_q <= '0;
        else
            q_q <= q_d;
    end

    assign q_o    = q_q;
    assign miso_o = sel_i & q_q[DATA_W-1];

endmodule

// File: rtl/spi.sv
// Master shift register plus transaction FSM; exchanges one byte with the
// slave addressed by a one-hot select (1 load cycle + 8 shift cycles).
module spi
    import spi_pkg::*;
(
    input  logic                clk,
    input  logic [N_SLAVES:1]   select,
    input  logic [DATA_W-1:0]   dataInMaster,
    input  logic [DATA_W-1:0]   dataInSlave1,
    input  logic [DATA_W-1:0]   dataInSlave2,
    input  logic [DATA_W-1:0]   dataInSlave3,
    input  logic [DATA_W-1:0]   dataInSlave4,
    output logic [N_SLAVES:1]   miso,
    output logic                mosi,
    output logic                MISO,
    output logic [DATA_W-1:0]   outMaster,
    output logic [DATA_W-1:0]   outSlave1,
    output logic [DATA_W-1:0]   outSlave2,
    output logic [DATA_W-1:0]   outSlave3,
    output logic [DATA_W-1:0]   outSlave4,
    input  logic                rst_n
);

    spi_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [N_SLAVES:1]    sel_q, sel_d;
    logic [DATA_W-1:0]    master_q, master_d;
    logic                 load, shift_en, sel_ok;

    logic [DATA_W-1:0]    slv_din [N_SLAVES:1];
    logic [DATA_W-1:0]    slv_q   [N_SLAVES:1];

    assign sel_ok = is_onehot(select);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        master_d = master_q;
        load     = 1'b0;
        shift_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Re-serving the slave just served needs select to move first.
                if (sel_ok && (select != sel_q))
                    state_d = LOAD;
            end
            LOAD: begin
                load     = 1'b1;
                master_d = dataInMaster;
                sel_d    = select;
                cnt_d    = '0;
                state_d  = SHIFT;
            end
            SHIFT: begin
                if (!sel_ok)
                    state_d = IDLE;
                else if (select != sel_q)
                    state_d = LOAD;
                else begin
                    shift_en = 1'b1;
                    master_d = {master_q[DATA_W-2:0], MISO};
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1))
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            master_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            master_q <= master_d;
        end
    end

    assign slv_din[1] = dataInSlave1;
    assign slv_din[2] = dataInSlave2;
    assign slv_din[3] = dataInSlave3;
    assign slv_din[4] = dataInSlave4;

    // miso is gated to SHIFT so the return line stays quiet in IDLE and LOAD.
    for (genvar i = 1; i <= N_SLAVES; i++) begin : g_slave
        spi_slave u_slave (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load),
            .shift_i (shift_en & sel_q[i]),
            .sel_i   (sel_q[i] & (state_q == SHIFT)),
            .data_i  (slv_din[i]),
            .mosi_i  (mosi),
            .q_o     (slv_q[i]),
            .miso_o  (miso[i])
        );
    end

    assign mosi      = master_q[DATA_W-1];
    assign MISO      = |miso;
    assign outMaster = master_q;
    assign outSlave1 = slv_q[1];
    assign outSlave2 = slv_q[2];
    assign outSlave3 = slv_q[3];
    assign outSlave4 = slv_q[4];

endmodule

// File: tb/tb_spi.sv
// Directed + randomized bench for spi; a transaction-level reference model
// treats an exchange as a 16-bit rotation of {master, selected slave}.
module tb_spi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:1] sel = 4'b0000;
    logic [7:0] dm = 8'h00;
    logic [7:0] ds [1:4];
    logic [4:1] miso;
    logic       mosi, MISO;
    logic [7:0] outMaster, outSlave1, outSlave2, outSlave3, outSlave4;

    int vectors = 0;
    int miscompares = 0;

    // reference model: phase 0 idle, 1 load, 2 shifting
    int         ph;
    int         n;
    logic [3:0] last;
    logic [7:0] m0;
    logic [7:0] sl [1:4];

    spi dut (
        .clk          (clk),
        .select       (sel),
        .dataInMaster (dm),
        .dataInSlave1 (ds[1]),
        .dataInSlave2 (ds[2]),
        .dataInSlave3 (ds[3]),
        .dataInSlave4 (ds[4]),
        .miso         (miso),
        .mosi         (mosi),
        .MISO         (MISO),
        .outMaster    (outMaster),
        .outSlave1    (outSlave1),
        .outSlave2    (outSlave2),
        .outSlave3    (outSlave3),
        .outSlave4    (outSlave4),
        .rst_n        (rst_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        assert (act === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        ph = 0; n = 0; last = 4'b0000; m0 = 8'h00;
        for (int i = 1; i <= 4; i++) sl[i] = 8'h00;
    endtask

    task automatic model_edge();
        bit valid;
        valid = ($countones(sel) == 1);
        if (!rst_n) begin
            model_reset();
        end else if (ph == 0) begin
            if (valid && sel != last) ph = 1;
        end else if (ph == 1) begin
            m0 = dm; last = sel; n = 0; ph = 2;
            for (int i = 1; i <= 4; i++) sl[i] = ds[i];
        end else begin
            if (!valid) ph = 0;
            else if (sel != last) ph = 1;
            else begin
                n++;
                if (n == 8) ph = 0;
            end
        end
    endtask

    task automatic check_model();
        logic [7:0]  em;
        logic [7:0]  es [1:4];
        logic [15:0] cat;
        logic [3:0]  emv;
        int          k;
        em = m0;
        k = 0;
        for (int i = 1; i <= 4; i++) es[i] = sl[i];
        if ($countones(last) == 1)
            for (int i = 1; i <= 4; i++) if (last[i-1]) k = i;
        if (k != 0 && n > 0) begin
            cat = {m0, sl[k]};
            cat = (cat << n) | (cat >> (16 - n));
            em = cat[15:8];
            es[k] = cat[7:0];
        end
        for (int i = 1; i <= 4; i++) emv[i-1] = (ph == 2 && last[i-1]) ? es[i][7] : 1'b0;
        chk("mdl_outMaster", outMaster, em);
        chk("mdl_outSlave1", outSlave1, es[1]);
        chk("mdl_outSlave2", outSlave2, es[2]);
        chk("mdl_outSlave3", outSlave3, es[3]);
        chk("mdl_outSlave4", outSlave4, es[4]);
        chk("mdl_mosi", {7'd0, mosi}, {7'd0, em[7]});
        chk("mdl_miso", {4'd0, miso}, {4'd0, emv});
        chk("mdl_MISO", {7'd0, MISO}, {7'd0, |emv});
    endtask

    task automatic tick(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_model();
        end
    endtask

    task automatic set_in(input logic [3:0] s, input logic [7:0] m,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
        sel = s; dm = m; ds[1] = a; ds[2] = b; ds[3] = c; ds[4] = d;
    endtask

    initial begin
        ds[1] = 8'h00; ds[2] = 8'h00; ds[3] = 8'h00; ds[4] = 8'h00;
        model_reset();
        #12;
        chk("rst_outMaster", outMaster, 8'h00);
        chk("rst_outSlave2", outSlave2, 8'h00);
        chk("rst_MISO", {7'd0, MISO}, 8'h00);
        check_model();
        @(negedge clk);
        rst_n = 1'b1;

        // basic exchange with slave 2
        set_in(4'b0010, 8'hF0, 8'h00, 8'h0F, 8'h00, 8'h00);
        tick(10);
        chk("x1_outMaster", outMaster, 8'h0F);
        chk("x1_outSlave2", outSlave2, 8'hF0);
        chk("x1_outSlave1", outSlave1, 8'h00);
        chk("x1_outSlave4", outSlave4, 8'h00);

        // slave 4; slave 2 reloaded from its input
        set_in(4'b1000, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF);
        tick(10);
        chk("x2_outMaster", outMaster, 8'hFF);
        chk("x2_outSlave4", outSlave4, 8'h00);
        chk("x2_outSlave2", outSlave2, 8'h00);

        // slave 1; slave 4 keeps its loaded value
        set_in(4'b0001, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h66);
        tick(10);
        chk("x3_outMaster", outMaster, 8'h00);
        chk("x3_outSlave1", outSlave1, 8'hFF);
        chk("x3_outSlave4", outSlave4, 8'h66);

        // multi-hot select from IDLE does nothing
        set_in(4'b0011, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A);
        for (int c = 0; c < 4; c++) begin
            tick(1);
            chk("mh_MISO", {7'd0, MISO}, 8'h00);
        end
        chk("mh_outMaster", outMaster, 8'h00);
        chk("mh_outSlave1", outSlave1, 8'hFF);
        chk("mh_outSlave4", outSlave4, 8'h66);

        // select moves mid-shift: restart with slave 3
        set_in(4'b0010, 8'hA5, 8'h11, 8'h3C, 8'hC3, 8'h22);
        tick(6);
        sel = 4'b0100;
        tick(10);
        chk("ab_outMaster", outMaster, 8'hC3);
        chk("ab_outSlave3", outSlave3, 8'hA5);
        chk("ab_outSlave2", outSlave2, 8'h3C);
        chk("ab_outSlave1", outSlave1, 8'h11);
        chk("ab_outSlave4", outSlave4, 8'h22);

        // reset pulse at shift 3
        set_in(4'b1000, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h96);
        tick(5);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mr_outMaster", outMaster, 8'h00);
        chk("mr_outSlave4", outSlave4, 8'h00);
        chk("mr_mosi", {7'd0, mosi}, 8'h00);
        chk("mr_MISO", {7'd0, MISO}, 8'h00);
        tick(2);
        @(negedge clk);
        rst_n = 1'b1;
        tick(10);
        chk("mr2_outMaster", outMaster, 8'h96);
        chk("mr2_outSlave4", outSlave4, 8'h5A);

        // randomized traffic, including invalid and mid-transfer select changes
        for (int t = 0; t < 60; t++) begin
            logic [3:0] s;
            case ($urandom_range(0, 9))
                0:       s = 4'b0000;
                1:       s = 4'($urandom_range(0, 15));
                default: s = 4'b0001 << $urandom_range(0, 3);
            endcase
            set_in(s, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            tick($urandom_range(1, 12));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi.md
SPI -- requirements
Module: spi

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset; last port in positional order.
REQ-003 Positional port order SHALL be: clk, select, dataInMaster, dataInSlave1, dataInSlave2, dataInSlave3, dataInSlave4, miso, mosi, MISO, outMaster, outSlave1, outSlave2, outSlave3, outSlave4, rst_n.
REQ-004 select  input  [4:1]  one-hot slave select; bit i selects slave i.
REQ-005 dataInMaster  input  8  byte the master transmits.
REQ-006 dataInSlave1..4  input  8 each  byte each slave transmits.
REQ-007 miso  output  [4:1]  per-slave serial out.
REQ-008 mosi  output  1  master serial out.
REQ-009 MISO  output  1  muxed serial line returned to master.
REQ-010 outMaster  output  8  master shift-register contents.
REQ-011 outSlave1..4  output  8 each  slave i shift-register contents.

Function
REQ-012 A select value SHALL be valid only when exactly one bit is set.
REQ-013 FSM states SHALL be IDLE, LOAD, SHIFT.
- IDLE->LOAD when select is valid and differs from the latched last-served select.
- LOAD->SHIFT after one cycle.
- SHIFT->IDLE after 8 shift cycles.
REQ-014 LOAD cycle SHALL:
- load master and all four slave registers from their dataIn ports;
- latch select;
- clear the bit counter.
REQ-015 Each SHIFT cycle, MSB first: master <= {master[6:0], MISO}; selected slave <= {slave[6:0], mosi}; counter += 1.
REQ-016 mosi SHALL equal master[7] combinationally.
REQ-017 miso[i] SHALL equal slave_i[7] when latched select bit i is set, else 0.
REQ-018 MISO SHALL equal the OR of miso[4:1].
REQ-019 Unselected slave registers SHALL hold their LOAD values throughout SHIFT.
REQ-020 Transaction length SHALL be 9 cycles (1 load + 8 shifts); on completion master holds the selected slave's byte and the selected slave holds the master's byte.
REQ-021 dataIn changes after LOAD SHALL be ignored until the next transaction.
REQ-022 If select changes to a different valid value during SHIFT, the FSM SHALL abort and enter LOAD next cycle with the new select.
REQ-023 Invalid select (zero or multi-hot) SHALL NOT start a transaction; during SHIFT it SHALL abort to IDLE.
REQ-024 In IDLE all registers SHALL hold and MISO SHALL be 0.
REQ-025 Out* outputs SHALL continuously reflect the shift registers.

Reset
REQ-026 rst_n low SHALL asynchronously force:
- state IDLE;
- counter 0;
- latched select 4'b0000;
- all shift registers, and therefore all outputs (outMaster, outSlave1..4, mosi, miso, MISO), to 0.
REQ-027 Reset mid-transaction SHALL discard it; after release, any valid select starts a new transaction.

Structure
REQ-028 Shared package spi_pkg SHALL hold DATA_W=8, N_SLAVES=4 and the state enum.
REQ-029 Sub-module spi_slave (8-bit load/shift register with enable and miso gating) SHALL be instantiated 4 times; master register and FSM reside in spi.

Verification
REQ-030 Reset, then select=0010, master=F0, slave2=0F, others 00 -> after 9 cycles outMaster=0F, outSlave2=F0, others 00.
REQ-031 Then select=1000, master=00, slave4=FF -> outMaster=FF, outSlave4=00, outSlave2=00 (reloaded).
REQ-032 Then select=0001, master=FF, slave1=00, slave4=66 -> outMaster=00, outSlave1=FF, outSlave4=66 (unshifted).
REQ-033 select=0011 from IDLE -> no transaction, MISO=0, registers unchanged.
REQ-034 select changed 0010->0100 at shift 4 -> restart; after 9 further cycles exchange is with slave3 only.
REQ-035 rst_n pulsed low at shift 3 -> all outputs 0 immediately; FSM returns to IDLE.
